// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
// The FIFO entry pairs a destination register with its result data.
package wb_pkg;

  localparam int WB_FIFO_DEPTH = 4;
  localparam int WB_STALL_AGE  = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic [31:0] reg_onehot(input logic [4:0] r);
    reg_onehot = 32'd1 << r;
  endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Multicycle-result queue: power-of-two depth with wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = WB_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rf_rst_n,
  input  logic      i_push,
  input  wb_entry_t i_wdata,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_full,
  output logic      o_empty,
  output logic [AW:0] o_count
);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  wb_entry_t   r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // pointer stage
  always_ff @(posedge clk or posedge rf_rst_n) begin
    if (rf_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // storage stage
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: single-cycle ALU results take priority over
// queued mul/div results; tracks pending destinations and requests upstream stall.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter  int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter  int STALL_AGE  = WB_STALL_AGE,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rf_rst_n,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [4:0]    md_rd,
  input  logic [31:0]   md_data,
  input  logic          md_issue,
  input  logic [4:0]    md_issue_rd,
  output logic          rf_w,
  output logic [4:0]    Rdc,
  output logic [31:0]   Rd_in,
  output logic [31:0]   busy_mask,
  output logic          stall_req,
  output logic [CW-1:0] fifo_count
);

  localparam int               AGE_W   = $clog2(STALL_AGE) + 1;
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STALL_AGE - 1);

  wb_entry_t        w_head;
  wb_entry_t        w_push_entry;
  wb_entry_t        w_sel;
  logic             w_sel_vld;
  logic             w_wr_en;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_set;
  logic [31:0]      w_clr;

  logic             r_rf_w;
  logic [4:0]       r_rdc;
  logic [31:0]      r_rd_in;
  logic [31:0]      r_busy;
  logic [AGE_W-1:0] r_age;
  logic             r_stall;

  assign w_push       = md_valid && !w_full;
  assign w_pop        = !alu_valid && !w_empty;
  assign w_push_entry = '{rd: md_rd, data: md_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rf_rst_n (rf_rst_n),
    .i_push   (w_push),
    .i_wdata  (w_push_entry),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (fifo_count)
  );

  // source select: ALU wins, otherwise the FIFO head
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    if (alu_valid) begin
      w_sel_vld = 1'b1;
      w_sel     = '{rd: alu_rd, data: alu_data};
    end else if (w_pop) begin
      w_sel_vld = 1'b1;
      w_sel     = w_head;
    end
  end

  assign w_wr_en = w_sel_vld && (w_sel.rd != REG_ZERO);
  assign w_set   = (md_issue && (md_issue_rd != REG_ZERO)) ? reg_onehot(md_issue_rd) : '0;
  assign w_clr   = w_pop ? reg_onehot(w_head.rd) : '0;

  // write-port register stage; Rdc/Rd_in hold when nothing is written
  always_ff @(posedge clk or posedge rf_rst_n) begin
    if (rf_rst_n) begin
      r_rf_w  <= 1'b0;
      r_rdc   <= '0;
      r_rd_in <= '0;
    end else begin
      r_rf_w <= w_wr_en;
      if (w_wr_en) begin
        r_rdc   <= w_sel.rd;
        r_rd_in <= w_sel.data;
      end
    end
  end

  // scoreboard stage: set overrides a same-cycle clear
  always_ff @(posedge clk or posedge rf_rst_n) begin
    if (rf_rst_n) r_busy <= '0;
    else          r_busy <= (r_busy & ~w_clr) | w_set;
  end

  // head-age and stall stage
  always_ff @(posedge clk or posedge rf_rst_n) begin
    if (rf_rst_n) begin
      r_age   <= '0;
      r_stall <= 1'b0;
    end else begin
      if (w_pop || !w_full)   r_age <= '0;
      else if (r_age != AGE_LIM) r_age <= r_age + AGE_W'(1);

      if (w_pop)                          r_stall <= 1'b0;
      else if (w_full && r_age == AGE_LIM) r_stall <= 1'b1;
    end
  end

  assign md_ready  = !w_full;
  assign rf_w      = r_rf_w;
  assign Rdc       = r_rdc;
  assign Rd_in     = r_rd_in;
  assign busy_mask = r_busy;
  assign stall_req = r_stall;

`ifndef SYNTHESIS
  a_no_alu_during_stall : assert property (
    @(posedge clk) disable iff (rf_rst_n) !(alu_valid && stall_req)
  ) else $error("wb_arbiter: alu_valid asserted while stall_req is high");
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: table of per-cycle vectors with hand-derived expectations
// queued on drive and compared after the edge, plus full-FIFO and reset sequences.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rf_rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        rf_w;
  logic [4:0]  Rdc;
  logic [31:0] Rd_in;
  logic [31:0] busy_mask;
  logic        stall_req;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  wb_arbiter #(
    .FIFO_DEPTH (4),
    .STALL_AGE  (4)
  ) dut (
    .clk         (clk),
    .rf_rst_n    (rf_rst_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .md_valid    (md_valid),
    .md_ready    (md_ready),
    .md_rd       (md_rd),
    .md_data     (md_data),
    .md_issue    (md_issue),
    .md_issue_rd (md_issue_rd),
    .rf_w        (rf_w),
    .Rdc         (Rdc),
    .Rd_in       (Rd_in),
    .busy_mask   (busy_mask),
    .stall_req   (stall_req),
    .fifo_count  (fifo_count)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        iss;
    logic [4:0]  ird;
    logic        ew;
    logic [4:0]  erd;
    logic [31:0] edata;
    int          ecnt;
    logic [31:0] ebusy;
    logic        cd;
  } vec_t;

  typedef struct {
    logic        ew;
    logic [4:0]  erd;
    logic [31:0] edata;
    int          ecnt;
    logic [31:0] ebusy;
    logic        cd;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mkv(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                               input logic iss, input logic [4:0] ird,
                               input logic ew, input logic [4:0] erd, input logic [31:0] edata,
                               input int ecnt, input logic [31:0] ebusy, input logic cd);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.mv = mv; v.mrd = mrd; v.md = md;
    v.iss = iss; v.ird = ird;
    v.ew = ew; v.erd = erd; v.edata = edata;
    v.ecnt = ecnt; v.ebusy = ebusy; v.cd = cd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  task automatic drive_idle();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    md_issue = 1'b0; md_issue_rd = 5'd0;
  endtask

  task automatic tick(input vec_t v, input string nm);
    exp_t e;
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    md_valid = v.mv; md_rd = v.mrd; md_data = v.md;
    md_issue = v.iss; md_issue_rd = v.ird;
    sb.push_back('{v.ew, v.erd, v.edata, v.ecnt, v.ebusy, v.cd});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({nm, ".rf_w"}, 32'(rf_w), 32'(e.ew));
    if (e.cd) begin
      chk({nm, ".Rdc"}, 32'(Rdc), 32'(e.erd));
      chk({nm, ".Rd_in"}, Rd_in, e.edata);
    end
    chk({nm, ".fifo_count"}, 32'(fifo_count), 32'(e.ecnt));
    chk({nm, ".md_ready"}, 32'(md_ready), 32'(e.ecnt < 4));
    chk({nm, ".busy_mask"}, busy_mask, e.ebusy);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".rf_w"}, 32'(rf_w), 32'd0);
    chk({nm, ".Rdc"}, 32'(Rdc), 32'd0);
    chk({nm, ".Rd_in"}, Rd_in, 32'd0);
    chk({nm, ".busy_mask"}, busy_mask, 32'd0);
    chk({nm, ".stall_req"}, 32'(stall_req), 32'd0);
    chk({nm, ".fifo_count"}, 32'(fifo_count), 32'd0);
    chk({nm, ".md_ready"}, 32'(md_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rf_rst_n = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rf_rst_n = 1'b0;

    // ALU only, then idle hold
    tbl.push_back(mkv(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 0, 32'h0, 1'b1));
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0,       1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 0, 32'h0, 1'b1));
    // ALU priority over a queued MD result
    tbl.push_back(mkv(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 1'b1, 5'd3, 32'h33,   1, 32'h0, 1'b1));
    tbl.push_back(mkv(1'b1, 5'd3, 32'h34, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 5'd3, 32'h34,   1, 32'h0, 1'b1));
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 5'd7, 32'h1234, 0, 32'h0, 1'b1));
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd7, 32'h1234, 0, 32'h0, 1'b1));
    // no bypass: push into empty is not popped the same cycle
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 1'b0, 5'd7, 32'h1234, 1, 32'h0, 1'b1));
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 5'd8, 32'h88,   0, 32'h0, 1'b1));
    // busy scoreboard set / clear / set-wins
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,   1'b1, 5'd9, 1'b0, 5'd8, 32'h88,  0, 32'h200, 1'b1));
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99,  1'b0, 5'd0, 1'b0, 5'd8, 32'h88,  1, 32'h200, 1'b1));
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 1'b1, 5'd9, 32'h99,  0, 32'h0,   1'b1));
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,   1'b1, 5'd9, 1'b0, 5'd9, 32'h99,  0, 32'h200, 1'b1));
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h999, 1'b0, 5'd0, 1'b0, 5'd9, 32'h99,  1, 32'h200, 1'b1));
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,   1'b1, 5'd9, 1'b1, 5'd9, 32'h999, 0, 32'h200, 1'b1));
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,   1'b1, 5'd0, 1'b0, 5'd9, 32'h999, 0, 32'h200, 1'b1));
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9A,  1'b1, 5'd4, 1'b0, 5'd9, 32'h999, 1, 32'h210, 1'b1));
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 1'b1, 5'd9, 32'h9A,  0, 32'h010, 1'b1));
    // zero-register results are dropped but still dequeued
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd9, 32'h9A, 1, 32'h010, 1'b1));
    tbl.push_back(mkv(1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  0, 32'h010, 1'b0));
    tbl.push_back(mkv(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  0, 32'h010, 1'b0));
    tbl.push_back(mkv(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd4, 32'h44, 0, 32'h010, 1'b1));

    for (int i = 0; i < tbl.size(); i++) tick(tbl[i], $sformatf("vec%0d", i));

    // fill the FIFO behind a continuous ALU stream
    for (int k = 0; k < 4; k++) begin
      tick(mkv(1'b1, 5'd1, 32'h100 + k, 1'b1, 5'(10 + k), 32'hA0 + k, 1'b0, 5'd0,
               1'b1, 5'd1, 32'h100 + k, k + 1, 32'h010, 1'b1), $sformatf("fill%0d", k));
      chk($sformatf("fill%0d.stall_req", k), 32'(stall_req), 32'd0);
    end
    // full head ages; offered MD data must not be accepted
    for (int k = 0; k < 4; k++) begin
      tick(mkv(1'b1, 5'd1, 32'h110 + k, 1'b1, 5'd31, 32'hEE, 1'b0, 5'd0,
               1'b1, 5'd1, 32'h110 + k, 4, 32'h010, 1'b1), $sformatf("age%0d", k));
      chk($sformatf("age%0d.stall_req", k), 32'(stall_req), 32'(k == 3));
    end
    // drain in order; stall drops after the first pop
    for (int k = 0; k < 4; k++) begin
      tick(mkv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
               1'b1, 5'(10 + k), 32'hA0 + k, 3 - k, 32'h010, 1'b1), $sformatf("drain%0d", k));
      chk($sformatf("drain%0d.stall_req", k), 32'(stall_req), 32'd0);
    end
    tick(mkv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd13, 32'hA3, 0, 32'h010, 1'b1), "drained");

    // queue three pending results, then reset mid-stream
    for (int k = 0; k < 3; k++) begin
      tick(mkv(1'b1, 5'd2, 32'h200 + k, 1'b1, 5'(20 + k), 32'hB0 + k, 1'b1, 5'(20 + k),
               1'b1, 5'd2, 32'h200 + k, k + 1, 32'h010 | (32'h0010_0000 << (k + 1)) - 32'h0010_0000, 1'b1),
           $sformatf("queue%0d", k));
    end
    alu_valid = 1'b0;
    md_valid = 1'b1; md_rd = 5'd30; md_data = 32'hC0;
    md_issue = 1'b1; md_issue_rd = 5'd30;
    rf_rst_n = 1'b1;
    #1;
    chk_reset("async_rst");
    @(posedge clk);
    #1;
    chk_reset("rst_hold");
    drive_idle();
    rf_rst_n = 1'b0;
    tick(mkv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 0, 32'h0, 1'b1), "post_rst");
    tick(mkv(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd6, 32'h66, 0, 32'h0, 1'b1), "post_rst_alu");
    chk("post_rst.stall_req", 32'(stall_req), 32'd0);
    drive_idle();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the multicycle-result queue depth (power of two, at least 2).
REQ-002 SHALL have parameter STALL_AGE, default 4, meaning the number of cycles a full FIFO head may wait before stall_req asserts.
REQ-003 SHALL have port clk  input  1  meaning the CPU clock; all state updates on its rising edge.
REQ-004 SHALL have port rf_rst_n  input  1  meaning reset, asynchronous, active-high.
REQ-005 SHALL have ports alu_valid  input  1, alu_rd  input  5 and alu_data  input  32, meaning a single-cycle result, with no backpressure.
REQ-006 SHALL have ports md_valid  input  1, md_ready  output  1, md_rd  input  5 and md_data  input  32, meaning a mul/div result stream using a valid/ready handshake.
REQ-007 SHALL have ports md_issue  input  1 and md_issue_rd  input  5, meaning a multicycle op has been issued to the destination md_issue_rd.
REQ-008 SHALL have ports rf_w  output  1, Rdc  output  5 and Rd_in  output  32, meaning the drive to the register-file write port.
REQ-009 SHALL have port busy_mask  output  32  meaning that bit i=1 marks register i as pending a multicycle result.
REQ-010 SHALL have port stall_req  output  1  meaning that upstream must hold alu_valid=0 while it is high.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  meaning the current FIFO occupancy.

Function
REQ-012 rf_w, Rdc and Rd_in SHALL be registered on the rising edge of clk, so they are stable at the register file's falling-edge write.
REQ-013 SHALL give 1-cycle latency: alu_valid at edge N produces rf_w=1, Rdc=alu_rd and Rd_in=alu_data after edge N+1.
REQ-014 SHALL define an MD transfer as md_valid && md_ready at a rising edge; the transfer pushes {md_rd, md_data} into the FIFO tail.
REQ-015 md_ready SHALL be combinational, equal to !full; it SHALL NOT depend on md_valid.
REQ-016 SHALL give priority to ALU: in any cycle with alu_valid=1, the FIFO is not popped.
REQ-017 In a cycle with alu_valid=0 and a non-empty FIFO, the head SHALL be popped and presented on the write port after the next edge.
REQ-018 In a cycle with no ALU result and an empty FIFO, rf_w SHALL be 0 after the next edge; Rdc and Rd_in hold their previous values.
REQ-019 SHALL allow a push and a pop in the same cycle when the FIFO is full, because the pop frees the slot; fifo_count is then unchanged.
REQ-020 A push into an empty FIFO SHALL NOT be popped in the same cycle; the minimum MD latency is 2 edges, i.e. there is no bypass.
REQ-021 Any write with rd=0 SHALL be dropped (rf_w=0); the FIFO entry is still popped.
REQ-022 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-023 md_issue with md_issue_rd!=0 SHALL set busy_mask[md_issue_rd] at the next edge; md_issue_rd=0 is ignored.
REQ-024 A pop of a FIFO entry with rd=r SHALL clear busy_mask[r] at the same edge the write is registered.
REQ-025 On a simultaneous set and clear of the same bit, the set SHALL win.
REQ-026 The age counter SHALL increment each cycle the FIFO is full and no pop occurs, and SHALL clear on any pop.
REQ-027 stall_req SHALL be registered and SHALL assert when the age counter reaches STALL_AGE-1.
REQ-028 stall_req SHALL deassert the edge after the next pop.
REQ-029 SHALL treat alu_valid=1 while stall_req=1 as a protocol error: the ALU write still occurs, and in simulation an assertion fires.

Reset
REQ-030 While rf_rst_n=1, regardless of clk, the block SHALL force: rf_w=0, Rdc=0, Rd_in=0, busy_mask=0, stall_req=0, fifo_count=0, pointers=0, age counter=0.
REQ-031 md_ready SHALL be 1 during and after reset because the FIFO is empty; pushes are ignored while reset is active.
REQ-032 Assertion of reset mid-operation SHALL discard FIFO contents with no partial write; the first write after release comes from new input.

Structure
REQ-033 Package wb_pkg SHALL hold the FIFO_DEPTH and STALL_AGE defaults, the wb_entry_t struct {rd[4:0], data[31:0]} and the REG_ZERO constant.
REQ-034 The FIFO SHALL be the sub-module wb_fifo (push/pop/full/empty/count, async reset rf_rst_n); arbitration, scoreboard and stall logic live in wb_arbiter.

Verification
REQ-035 Reset mid-stream: 3 entries queued, rf_rst_n pulsed -> fifo_count=0, busy_mask=0, md_ready=1, rf_w=0 until new input.
REQ-036 ALU only: alu_valid with rd=5, data=0xDEADBEEF at edge 1 -> rf_w=1, Rdc=5, Rd_in=0xDEADBEEF after edge 2; rf_w=0 after edge 3.
REQ-037 Priority: alu_valid (rd=3) held 2 cycles while an MD push (rd=7, 0x1234) occurs -> writes in order rd=3, rd=3, then rd=7 (0x1234).
REQ-038 Full FIFO: 4 pushes with alu_valid held high -> md_ready=0 and stall_req=1 after 4 aged cycles; alu_valid dropped -> pop rd order preserved, stall_req=0 the edge after the pop.
REQ-039 Scoreboard: md_issue rd=9 -> busy_mask=0x200; MD result rd=9 popped -> bit cleared at the write edge; simultaneous re-issue of rd=9 -> bit stays 1.
REQ-040 Zero register: MD result rd=0, data=0xFFFFFFFF -> rf_w=0, FIFO decrements, busy_mask unchanged.
